// File: rtl/lisnoc_mp_wb_master_if.sv
// Bundles the LISNoC input link and the Wishbone initiator bus of lisnoc_mp_wb_master.
// Handshake: a flit moves on a rising edge where noc_in_valid && noc_in_ready; valid/flit hold until then.
interface lisnoc_mp_wb_master_if #(
    parameter int noc_data_width = 32,
    parameter int noc_type_width = 2
);
    logic [noc_data_width+noc_type_width-1:0] noc_in_flit;
    logic                                     noc_in_valid;
    logic                                     noc_in_ready;

    logic [31:0]                              wb_adr_o;
    logic [noc_data_width-1:0]                wb_dat_o;
    logic [noc_data_width/8-1:0]              wb_sel_o;
    logic                                     wb_we_o;
    logic                                     wb_cyc_o;
    logic                                     wb_stb_o;
    logic                                     wb_ack_i;
    logic                                     wb_err_i;

    logic                                     done;
    logic                                     error;

    modport master (
        input  noc_in_flit, noc_in_valid,
        output noc_in_ready,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_ack_i, wb_err_i,
        output done, error
    );

    modport slave (
        output noc_in_flit, noc_in_valid,
        input  noc_in_ready,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_ack_i, wb_err_i,
        input  done, error
    );
endinterface

// File: rtl/lisnoc_mp_wb_master.sv
// NoC-to-Wishbone write initiator: flit 2 of a packet sets the start address, each
// following flit becomes one Wishbone single write at consecutive word addresses.
module lisnoc_mp_wb_master #(
    parameter int noc_data_width = 32,
    parameter int noc_type_width = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    lisnoc_mp_wb_master_if.master        bus,
    output logic [2:0]                   dbg_state
);
    localparam int flit_width = noc_data_width + noc_type_width;

    localparam logic [noc_type_width-1:0] type_payload = 2'b00;
    localparam logic [noc_type_width-1:0] type_header  = 2'b01;
    localparam logic [noc_type_width-1:0] type_last    = 2'b10;

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_addr  = 3'd1,
        st_data  = 3'd2,
        st_wb    = 3'd3,
        st_drain = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [31:0]                 addr_q, addr_d;
    logic [noc_data_width-1:0]   data_q, data_d;
    logic                        last_q, last_d;
    logic                        cyc_q;
    logic                        done_q, done_d;
    logic                        error_q, error_d;

    logic [noc_type_width-1:0]   flit_type;
    logic [noc_data_width-1:0]   flit_data;
    logic                        ready;
    logic                        accept;

    assign flit_type = bus.noc_in_flit[flit_width-1 -: noc_type_width];
    assign flit_data = bus.noc_in_flit[noc_data_width-1:0];

    // State register plus the datapath/output flops it steers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= st_idle;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cyc_q   <= (state_d == st_wb);
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state logic; ack/err only matter in st_wb, err wins over a concurrent ack.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            st_idle: begin
                if (accept && flit_type == type_header) state_d = st_addr;
            end
            st_addr: begin
                if (accept) begin
                    if (flit_type == type_last) begin
                        state_d = st_idle;
                    end else begin
                        addr_d  = {flit_data[31:2], 2'b00};
                        state_d = st_data;
                    end
                end
            end
            st_data: begin
                if (accept) begin
                    data_d  = flit_data;
                    last_d  = (flit_type == type_last);
                    state_d = st_wb;
                end
            end
            st_wb: begin
                if (bus.wb_err_i) begin
                    error_d = 1'b1;
                    state_d = last_q ? st_idle : st_drain;
                end else if (bus.wb_ack_i) begin
                    addr_d  = addr_q + 32'd4;
                    done_d  = last_q;
                    state_d = last_q ? st_idle : st_data;
                end
            end
            st_drain: begin
                if (accept && flit_type == type_last) state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase
    end

    // Output decode; noc_in_ready is the only combinational output.
    always_comb begin
        ready  = (state_q != st_wb) && !rst;
        accept = bus.noc_in_valid && ready;
    end

    assign bus.noc_in_ready = ready;
    assign bus.wb_adr_o     = addr_q;
    assign bus.wb_dat_o     = data_q;
    assign bus.wb_sel_o     = '1;
    assign bus.wb_cyc_o     = cyc_q;
    assign bus.wb_stb_o     = cyc_q;
    assign bus.wb_we_o      = cyc_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign dbg_state        = state_q;

    logic unused_payload_const;
    assign unused_payload_const = ^type_payload;
endmodule

// File: tb/tb_lisnoc_mp_wb_master.sv
// Directed bench for lisnoc_mp_wb_master: NoC flit driver, Wishbone slave model with
// wait states / error injection, write log checked against an expected queue.
module tb_lisnoc_mp_wb_master;
  localparam logic [1:0] t_pay  = 2'b00;
  localparam logic [1:0] t_hdr  = 2'b01;
  localparam logic [1:0] t_last = 2'b10;
  localparam logic [1:0] t_sgl  = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle_n = 0;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  lisnoc_mp_wb_master_if bus ();
  logic [2:0] dbg_state;

  lisnoc_mp_wb_master dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          len_q[$];
  int          start_q[$];
  int          got_base = 0;
  int          passed = 0;
  int          total = 0;

  // slave / monitor state
  int wait_states = 0;
  int err_at = -1;
  int wr_n = 0;
  int wait_cnt = 0;
  int ack_at = -1;
  int done_cnt = 0;
  int done_at = -1;
  int err_cnt = 0;
  int ready_viol = 0;
  int stable_viol = 0;
  logic [63:0] hold_val = '0;

  // Wishbone slave model
  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      if (bus.wb_cyc_o && !rst) begin
        if (wait_cnt == 0) begin
          start_q.push_back(cycle_n);
          hold_val = {bus.wb_adr_o, bus.wb_dat_o};
        end else if (hold_val !== {bus.wb_adr_o, bus.wb_dat_o}) begin
          stable_viol++;
        end
        if (wait_cnt == wait_states) begin
          got_q.push_back({bus.wb_adr_o, bus.wb_dat_o});
          len_q.push_back(wait_cnt + 1);
          bus.wb_ack_i = 1'b1;
          if (wr_n == err_at) bus.wb_err_i = 1'b1;
          ack_at = cycle_n + 1;
          wr_n++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // pulse / handshake monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.done) begin
        done_cnt++;
        done_at = cycle_n;
      end
      if (bus.error) err_cnt++;
      if (bus.wb_cyc_o && bus.noc_in_ready) ready_viol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] d);
    int n;
    n = 0;
    bus.noc_in_flit  = {t, d};
    bus.noc_in_valid = 1'b1;
    while (!bus.noc_in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      $error("FAIL send_timeout: observed ready=0 for %0d cycles expected ready=1", n);
    end else begin
      @(posedge clk); #1;
    end
    bus.noc_in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 64'(got_q.size() - got_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_base + i < got_q.size())
        check($sformatf("%s_w%0d", tag, i), got_q[got_base + i], exp_q[i]);
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  int d0, e0, s0, n0;

  initial begin
    bus.noc_in_flit  = '0;
    bus.noc_in_valid = 1'b0;

    // reset values
    rst = 1'b1;
    settle(2);
    check("rst_cyc",   64'(bus.wb_cyc_o), 64'd0);
    check("rst_stb",   64'(bus.wb_stb_o), 64'd0);
    check("rst_we",    64'(bus.wb_we_o),  64'd0);
    check("rst_adr",   64'(bus.wb_adr_o), 64'd0);
    check("rst_dat",   64'(bus.wb_dat_o), 64'd0);
    check("rst_sel",   64'(bus.wb_sel_o), 64'hF);
    check("rst_done",  64'(bus.done),     64'd0);
    check("rst_error", 64'(bus.error),    64'd0);
    check("rst_ready", 64'(bus.noc_in_ready), 64'd0);
    rst = 1'b0;
    settle(1);
    check("idle_ready", 64'(bus.noc_in_ready), 64'd1);

    // basic 3-write packet, zero-wait slave
    d0 = done_cnt; e0 = err_cnt; s0 = start_q.size();
    wait_states = 0;
    send(t_hdr, 32'h0);
    send(t_pay, 32'h0000_1000);
    send(t_pay, 32'hA);
    send(t_pay, 32'hB);
    send(t_last, 32'hC);
    settle(10);
    exp_q.push_back({32'h1000, 32'hA});
    exp_q.push_back({32'h1004, 32'hB});
    exp_q.push_back({32'h1008, 32'hC});
    check_writes("basic");
    check("basic_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("basic_done_at",  64'(done_at), 64'(ack_at));
    check("basic_err_cnt",  64'(err_cnt - e0), 64'd0);
    if (start_q.size() >= s0 + 2)
      check("basic_rate", 64'(start_q[s0 + 1] - start_q[s0]), 64'd2);
    if (len_q.size() >= 1) check("basic_len", 64'(len_q[len_q.size() - 1]), 64'd1);

    // misaligned address, 3 wait states
    d0 = done_cnt; n0 = len_q.size();
    wait_states = 3;
    send(t_hdr, 32'h0);
    send(t_pay, 32'h0000_1003);
    send(t_pay, 32'h1111);
    send(t_last, 32'h2222);
    settle(15);
    exp_q.push_back({32'h1000, 32'h1111});
    exp_q.push_back({32'h1004, 32'h2222});
    check_writes("wait");
    if (len_q.size() >= n0 + 2) begin
      check("wait_len0", 64'(len_q[n0]),     64'd4);
      check("wait_len1", 64'(len_q[n0 + 1]), 64'd4);
    end
    check("wait_done_cnt", 64'(done_cnt - d0), 64'd1);

    // address wrap
    wait_states = 0;
    send(t_hdr, 32'h0);
    send(t_pay, 32'hFFFF_FFFC);
    send(t_pay, 32'hAA);
    send(t_last, 32'hBB);
    settle(10);
    exp_q.push_back({32'hFFFF_FFFC, 32'hAA});
    exp_q.push_back({32'h0000_0000, 32'hBB});
    check_writes("wrap");

    // error on the 2nd write (ack raised too), remainder drained
    d0 = done_cnt; e0 = err_cnt;
    err_at = wr_n + 1;
    send(t_hdr, 32'h0);
    send(t_pay, 32'h2000);
    send(t_pay, 32'h11);
    send(t_pay, 32'h22);
    send(t_pay, 32'h33);
    send(t_last, 32'h44);
    settle(10);
    err_at = -1;
    exp_q.push_back({32'h2000, 32'h11});
    exp_q.push_back({32'h2004, 32'h22});
    check_writes("err");
    check("err_err_cnt",  64'(err_cnt - e0), 64'd1);
    check("err_done_cnt", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt;
    send(t_hdr, 32'h0);
    send(t_pay, 32'h3000);
    send(t_last, 32'h55);
    settle(10);
    exp_q.push_back({32'h3000, 32'h55});
    check_writes("after_err");
    check("after_err_done", 64'(done_cnt - d0), 64'd1);

    // stray flits and header+last packet
    d0 = done_cnt; e0 = err_cnt;
    send(t_sgl, 32'hDEAD);
    send(t_pay, 32'h1);
    send(t_last, 32'h2);
    send(t_hdr, 32'h0);
    send(t_last, 32'h1234);
    settle(5);
    check_writes("stray");
    check("stray_done", 64'(done_cnt - d0), 64'd0);
    check("stray_err",  64'(err_cnt - e0),  64'd0);

    // reset in the middle of the first write
    d0 = done_cnt; e0 = err_cnt;
    wait_states = 5;
    send(t_hdr, 32'h0);
    send(t_pay, 32'h5000);
    send(t_pay, 32'h1);
    check("mid_cyc_high", 64'(bus.wb_cyc_o), 64'd1);
    rst = 1'b1;
    settle(1);
    check("mid_cyc_low", 64'(bus.wb_cyc_o), 64'd0);
    rst = 1'b0;
    send(t_pay, 32'h2);
    send(t_last, 32'h3);
    settle(2);
    check("mid_done", 64'(done_cnt - d0), 64'd0);
    check("mid_err",  64'(err_cnt - e0),  64'd0);
    wait_states = 0;
    d0 = done_cnt;
    send(t_hdr, 32'h0);
    send(t_pay, 32'h6000);
    send(t_last, 32'h99);
    settle(10);
    exp_q.push_back({32'h6000, 32'h99});
    check_writes("post_rst");
    check("post_rst_done", 64'(done_cnt - d0), 64'd1);

    // whole-run invariants
    check("ready_in_wb", 64'(ready_viol),  64'd0);
    check("wb_stable",   64'(stable_viol), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
